irrigation_valve_sequencer: RTL and testbench

//  Control stage ahead of the 4-bit irrigation duration counter. Turns a

---
 rtl/irrigation_valve_sequencer_pkg.sv | 12 +
 rtl/irrigation_valve_sequencer_tick_prescaler.sv | 22 ++
 rtl/irrigation_valve_sequencer.sv | 89 ++++++++
 tb/tb_irrigation_valve_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/irrigation_valve_sequencer_pkg.sv
// Shared definitions for the irrigation valve sequencer: state encoding and default widths.
package irrigation_valve_sequencer_pkg;
  localparam int W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    COOL  = 3'd3,
    FAULT = 3'd4
  } state_e;
endpackage

// File: rtl/irrigation_valve_sequencer_tick_prescaler.sv
// Free-running tick generator; tick is a decode of the counter register, clr restarts the period.
module tick_prescaler #(
  parameter int PRESCALE = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                   cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/irrigation_valve_sequencer.sv
// Turns a soil-dry request into one timed watering cycle with cooldown and a sticky tank-low fault.
module irrigation_valve_sequencer
  import irrigation_valve_sequencer_pkg::*;
#(
  parameter int W              = W_DEF,
  parameter int PRESCALE       = 8,
  parameter int COOLDOWN_TICKS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         soil_dry,
  input  logic         enable,
  input  logic         tank_low,
  input  logic         abort,
  input  logic         fault_clr,
  input  logic [W-1:0] duration,
  output logic         tick,
  output logic         load,
  output logic         count_en,
  output logic [W-1:0] dur_out,
  output logic         valve_on,
  output logic         busy,
  output logic         fault,
  output logic [W-1:0] remaining
);
  localparam logic [W-1:0] COOL_INIT = W'(COOLDOWN_TICKS);
  localparam logic [W-1:0] ONE       = W'(1);

  state_e state, nxt;
  logic   cool_entry;
  logic   clr;

  // Phase restarts at LOAD and on COOL entry so every phase is whole ticks long.
  assign cool_entry = (state == RUN) && (nxt == COOL);
  assign clr        = (state == LOAD) || cool_entry;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (tank_low)                                nxt = FAULT;
             else if (soil_dry && enable && duration != '0) nxt = LOAD;
      LOAD:  if (tank_low) nxt = FAULT;
             else          nxt = RUN;
      RUN:   if (tank_low)                         nxt = FAULT;
             else if (abort)                       nxt = COOL;
             else if (tick && remaining == ONE)    nxt = COOL;
      COOL:  if (tank_low)                         nxt = FAULT;
             else if (tick && remaining == ONE)    nxt = IDLE;
      FAULT: if (fault_clr && !tank_low)           nxt = IDLE;
      default:                                     nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dur_out   <= '0;
      remaining <= '0;
    end else begin
      if (state == LOAD) dur_out <= duration;
      if (nxt == FAULT)
        remaining <= '0;
      else if (state == LOAD)
        remaining <= duration;
      else if (cool_entry)
        remaining <= COOL_INIT;
      // Guard on non-zero keeps the count from wrapping.
      else if ((state == RUN || state == COOL) && tick && remaining != '0)
        remaining <= remaining - ONE;
    end
  end

  assign load     = (state == LOAD);
  assign count_en = (state == RUN);
  assign valve_on = (state == RUN);
  assign busy     = (state == LOAD) || (state == RUN) || (state == COOL);
  assign fault    = (state == FAULT);
endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Scoreboard bench: expected measurements queued with each stimulus, popped as the DUT responds.
module tb_irrigation_valve_sequencer;
  localparam int W = 4, PRESCALE = 4, COOLDOWN_TICKS = 3;
  localparam int S_LOAD = 0, S_VALVE = 1, S_BUSY = 2, S_FAULT = 3;

  logic         CLK = 1'b0, RESET = 1'b0;
  logic         soil_dry = 1'b0, enable = 1'b0, tank_low = 1'b0, abort = 1'b0, fault_clr = 1'b0;
  logic [W-1:0] duration = '0;
  logic         tick, load, count_en, valve_on, busy, fault;
  logic [W-1:0] dur_out, remaining;
  logic [2*W+5:0] all_outs;

  int errs = 0, checks = 0;
  int exp_q[$];
  int n, nl, nv, nb, k, nt;
  bit mon_on = 1'b0;
  int rem_max = 0;

  irrigation_valve_sequencer #(.W(W), .PRESCALE(PRESCALE), .COOLDOWN_TICKS(COOLDOWN_TICKS)) dut (
    .CLK(CLK), .RESET(RESET), .soil_dry(soil_dry), .enable(enable), .tank_low(tank_low),
    .abort(abort), .fault_clr(fault_clr), .duration(duration), .tick(tick), .load(load),
    .count_en(count_en), .dur_out(dur_out), .valve_on(valve_on), .busy(busy), .fault(fault),
    .remaining(remaining)
  );

  assign all_outs = {tick, load, count_en, valve_on, busy, fault, dur_out, remaining};

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (mon_on && int'(remaining) > rem_max) rem_max = int'(remaining);

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input int got);
    if (exp_q.size() == 0) chk({tag, "_noexp"}, got, -1);
    else                   chk(tag, got, exp_q.pop_front());
  endtask

  function automatic logic sig(input int s);
    case (s)
      S_LOAD:  return load;
      S_VALVE: return valve_on;
      S_BUSY:  return busy;
      S_FAULT: return fault;
      default: return tick;
    endcase
  endfunction

  // Cycles (negedge samples) until signal s reaches lvl; returns maxc on timeout.
  task automatic wait_sig(input int s, input logic lvl, input int maxc, output int cnt);
    cnt = 0;
    while (sig(s) !== lvl && cnt < maxc) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  task automatic cyc(input int c);
    repeat (c) @(negedge CLK);
  endtask

  initial begin
    cyc(2);
    chk("rst_outs", int'(all_outs), 0);
    RESET = 1'b1;
    cyc(2);

    // normal cycle, duration 5
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(5);
    exp_q.push_back(1); exp_q.push_back(20); exp_q.push_back(3); exp_q.push_back(12);
    exp_q.push_back(0);
    enable = 1'b1; soil_dry = 1'b1; duration = 4'd5;
    wait_sig(S_LOAD, 1'b1, 10, n); pop_chk("t2_load_lat", n);
    soil_dry = 1'b0;
    wait_sig(S_LOAD, 1'b0, 10, n); pop_chk("t2_load_w", n);
    pop_chk("t2_rem_start", int'(remaining));
    pop_chk("t2_dur_out", int'(dur_out));
    pop_chk("t2_count_en", int'(count_en));
    wait_sig(S_VALVE, 1'b0, 40, n); pop_chk("t2_valve_w", n);
    pop_chk("t2_rem_cool", int'(remaining));
    wait_sig(S_BUSY, 1'b0, 40, n); pop_chk("t2_cool_w", n);
    pop_chk("t2_rem_idle", int'(remaining));

    // reset asserted mid-RUN
    exp_q.push_back(0); exp_q.push_back(0);
    soil_dry = 1'b1; duration = 4'd5;
    wait_sig(S_VALVE, 1'b1, 10, n);
    soil_dry = 1'b0;
    cyc(3);
    RESET = 1'b0;
    #1 pop_chk("t1_rst_outs", int'(all_outs));
    @(negedge CLK) RESET = 1'b1;
    cyc(2);
    pop_chk("t1_idle_busy", int'(busy));

    // zero duration is ignored
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    soil_dry = 1'b1; duration = 4'd0;
    nl = 0; nv = 0; nb = 0;
    repeat (12) begin
      @(negedge CLK);
      nl += int'(load); nv += int'(valve_on); nb += int'(busy);
    end
    pop_chk("t3_loads", nl); pop_chk("t3_valve", nv); pop_chk("t3_busy", nb);
    soil_dry = 1'b0;

    // abort outside RUN is ignored
    exp_q.push_back(0);
    abort = 1'b1; cyc(1); abort = 1'b0; cyc(1);
    pop_chk("abort_idle_busy", int'(busy));

    // abort on second tick, duration 9
    exp_q.push_back(1); exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(12);
    soil_dry = 1'b1; duration = 4'd9;
    wait_sig(S_LOAD, 1'b1, 10, n);
    soil_dry = 1'b0;
    wait_sig(S_VALVE, 1'b1, 10, n); pop_chk("t4_valve_lat", n);
    k = 0; nt = 0;
    while (k < 20) begin
      if (tick) begin
        nt++;
        if (nt == 2) break;
      end
      @(negedge CLK);
      k++;
    end
    pop_chk("t4_tick2_at", k);
    pop_chk("t4_rem_tick2", int'(remaining));
    abort = 1'b1;
    @(negedge CLK) abort = 1'b0;
    pop_chk("t4_valve_off", int'(valve_on));
    pop_chk("t4_busy_cool", int'(busy));
    pop_chk("t4_rem_cool", int'(remaining));
    wait_sig(S_BUSY, 1'b0, 40, n); pop_chk("t4_cool_w", n);

    // tank_low beats abort in RUN, sticky fault
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    soil_dry = 1'b1; duration = 4'd9;
    wait_sig(S_LOAD, 1'b1, 10, n);
    soil_dry = 1'b0;
    wait_sig(S_VALVE, 1'b1, 10, n);
    cyc(2);
    tank_low = 1'b1; abort = 1'b1;
    @(negedge CLK) abort = 1'b0;
    pop_chk("t5_fault", int'(fault));
    pop_chk("t5_valve", int'(valve_on));
    pop_chk("t5_busy", int'(busy));
    pop_chk("t5_rem", int'(remaining));
    fault_clr = 1'b1;
    @(negedge CLK) fault_clr = 1'b0;
    pop_chk("t5_clr_blocked", int'(fault));
    tank_low = 1'b0; fault_clr = 1'b1;
    @(negedge CLK) fault_clr = 1'b0;
    pop_chk("t5_cleared", int'(fault));
    pop_chk("t5_idle_busy", int'(busy));

    // back-to-back cycles with soil_dry held, duration 2
    exp_q.push_back(8); exp_q.push_back(14); exp_q.push_back(8); exp_q.push_back(14);
    exp_q.push_back(20); exp_q.push_back(3); exp_q.push_back(0);
    soil_dry = 1'b1; duration = 4'd2;
    mon_on = 1'b1;
    wait_sig(S_VALVE, 1'b1, 10, n);
    for (int c = 0; c < 2; c++) begin
      wait_sig(S_VALVE, 1'b0, 40, n); pop_chk("t6_valve_w", n);
      wait_sig(S_VALVE, 1'b1, 40, n); pop_chk("t6_gap", n);
    end
    soil_dry = 1'b0;
    wait_sig(S_BUSY, 1'b0, 60, n); pop_chk("t6_last_busy", n);
    mon_on = 1'b0;
    pop_chk("t6_rem_max", rem_max);
    pop_chk("t6_rem_end", int'(remaining));

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
